// File: rtl/core_pkg.sv
// Shared types for the core pipeline: write-back source select, load/store
// function codes and the write-back stage FSM states.
package core_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LSU  = 2'd1,
    WB_PC4  = 2'd2,
    WB_UIMM = 2'd3
  } write_back_mux_selector;

  // Encoding follows the RISC-V funct3 for loads; stores sit above bit 3.
  typedef enum logic [3:0] {
    LSU_LB   = 4'h0,
    LSU_LH   = 4'h1,
    LSU_LW   = 4'h2,
    LSU_LBU  = 4'h4,
    LSU_LHU  = 4'h5,
    LSU_SB   = 4'h8,
    LSU_SH   = 4'h9,
    LSU_SW   = 4'hA,
    LSU_NONE = 4'hF
  } load_store_func_code;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } wb_state_t;

endpackage

// File: rtl/wb_stage_load_align.sv
// Combinational load aligner: picks the addressed byte/half from a raw word,
// extends it, and flags accesses that are not naturally aligned.
module load_align
  import core_pkg::*;
(
  input  load_store_func_code op_i,
  input  logic [1:0]          offset_i,
  input  logic [31:0]         raw_i,
  output logic [31:0]         data_o,
  output logic                misaligned_o
);

  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign shifted  = raw_i >> {offset_i, 3'b000};
  assign byte_sel = shifted[7:0];
  assign half_sel = offset_i[1] ? raw_i[31:16] : raw_i[15:0];

  always_comb begin
    data_o       = raw_i;
    misaligned_o = 1'b0;
    case (op_i)
      LSU_LB:  data_o = {{24{byte_sel[7]}}, byte_sel};
      LSU_LBU: data_o = {24'h0, byte_sel};
      LSU_LH: begin
        data_o       = {{16{half_sel[15]}}, half_sel};
        misaligned_o = offset_i[0];
      end
      LSU_LHU: begin
        data_o       = {16'h0, half_sel};
        misaligned_o = offset_i[0];
      end
      LSU_LW: begin
        data_o       = raw_i;
        misaligned_o = (offset_i != 2'b00);
      end
      // Non-load codes pass the raw word through untouched.
      default: begin
        data_o       = raw_i;
        misaligned_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: selects the result source, aligns load data, drives the
// registered register-file write port and its bypass copy, and counts retires.
module wb_stage
  import core_pkg::*;
#(
  parameter int LOAD_TIMEOUT = 16,
  parameter int RETIRE_W     = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wb_valid_ip,
  input  write_back_mux_selector wb_mux_ip,
  input  logic [31:0]            wb_alu_result_ip,
  input  logic [4:0]             write_reg_addr_ip,
  input  logic [31:0]            pc_addr_ip,
  input  logic [31:0]            uimmd_ip,
  input  load_store_func_code    lsu_operator_ip,
  input  logic [1:0]             mem_addr_lo_ip,
  input  logic [31:0]            load_data_ip,
  input  logic                   load_data_valid_ip,
  output logic                   regfile_we_op,
  output logic [4:0]             regfile_waddr_op,
  output logic [31:0]            regfile_wdata_op,
  output logic                   fwd_valid_op,
  output logic [4:0]             fwd_addr_op,
  output logic [31:0]            fwd_data_op,
  output logic                   stall_op,
  output logic                   misalign_op,
  output logic                   load_timeout_op,
  output logic [RETIRE_W-1:0]    retired_count_op
);

  localparam int CNT_W = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOAD_TIMEOUT - 1);

  wb_state_t           state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [4:0]          ld_rd_q, ld_rd_d;
  load_store_func_code ld_op_q, ld_op_d;
  logic [1:0]          ld_off_q, ld_off_d;
  logic                we_q, we_d;
  logic [4:0]          waddr_q, waddr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                misalign_q, misalign_d;
  logic                timeout_q, timeout_d;
  logic [RETIRE_W-1:0] retired_q, retired_d;

  load_store_func_code al_op;
  logic [1:0]          al_off;
  logic [31:0]         al_data;
  logic                al_mis;

  logic                complete;
  logic                src_lsu;
  logic                misaligned;
  logic                do_write;
  logic [4:0]          rd_sel;
  logic [31:0]         result;

  // While waiting, the aligner must see the operator captured at issue time.
  assign al_op  = (state_q == WAIT_LOAD) ? ld_op_q  : lsu_operator_ip;
  assign al_off = (state_q == WAIT_LOAD) ? ld_off_q : mem_addr_lo_ip;

  load_align u_load_align (
    .op_i         (al_op),
    .offset_i     (al_off),
    .raw_i        (load_data_ip),
    .data_o       (al_data),
    .misaligned_o (al_mis)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ld_rd_d   = ld_rd_q;
    ld_op_d   = ld_op_q;
    ld_off_d  = ld_off_q;
    timeout_d = timeout_q;
    complete  = 1'b0;
    src_lsu   = 1'b0;
    rd_sel    = write_reg_addr_ip;

    case (state_q)
      IDLE: begin
        if (wb_valid_ip) begin
          if (wb_mux_ip != WB_LSU) begin
            complete = 1'b1;
          end else if (load_data_valid_ip) begin
            complete = 1'b1;
            src_lsu  = 1'b1;
          end else begin
            state_d  = WAIT_LOAD;
            cnt_d    = '0;
            ld_rd_d  = write_reg_addr_ip;
            ld_op_d  = lsu_operator_ip;
            ld_off_d = mem_addr_lo_ip;
          end
        end
      end
      WAIT_LOAD: begin
        rd_sel  = ld_rd_q;
        src_lsu = 1'b1;
        if (load_data_valid_ip) begin
          complete = 1'b1;
          state_d  = IDLE;
          cnt_d    = '0;
        end else if (cnt_q == CNT_LAST) begin
          // Load abandoned: flag it, no write and no retire.
          timeout_d = 1'b1;
          state_d   = IDLE;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (src_lsu) begin
      result = al_data;
    end else begin
      case (wb_mux_ip)
        WB_PC4:  result = pc_addr_ip + 32'd4;
        WB_UIMM: result = uimmd_ip;
        default: result = wb_alu_result_ip;
      endcase
    end

    misaligned = src_lsu & al_mis;
    do_write   = complete & ~misaligned & (rd_sel != 5'd0);
    we_d       = do_write;
    waddr_d    = do_write ? rd_sel : waddr_q;
    wdata_d    = do_write ? result : wdata_q;
    misalign_d = complete & misaligned;
    retired_d  = retired_q + {{(RETIRE_W-1){1'b0}}, complete};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ld_rd_q    <= 5'd0;
      ld_op_q    <= LSU_NONE;
      ld_off_q   <= 2'b00;
      we_q       <= 1'b0;
      waddr_q    <= 5'd0;
      wdata_q    <= 32'd0;
      misalign_q <= 1'b0;
      timeout_q  <= 1'b0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ld_rd_q    <= ld_rd_d;
      ld_op_q    <= ld_op_d;
      ld_off_q   <= ld_off_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      misalign_q <= misalign_d;
      timeout_q  <= timeout_d;
      retired_q  <= retired_d;
    end
  end

  assign regfile_we_op    = we_q;
  assign regfile_waddr_op = waddr_q;
  assign regfile_wdata_op = wdata_q;
  assign fwd_valid_op     = we_q;
  assign fwd_addr_op      = waddr_q;
  assign fwd_data_op      = wdata_q;
  assign stall_op         = (state_q == WAIT_LOAD);
  assign misalign_op      = misalign_q;
  assign load_timeout_op  = timeout_q;
  assign retired_count_op = retired_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: a table of single-cycle vectors plus
// hand-written sequences for delayed loads, timeout and reset mid-load.
module tb_wb_stage;
  import core_pkg::*;

  logic                   clock;
  logic                   reset;
  logic                   wb_valid_ip;
  write_back_mux_selector wb_mux_ip;
  logic [31:0]            wb_alu_result_ip;
  logic [4:0]             write_reg_addr_ip;
  logic [31:0]            pc_addr_ip;
  logic [31:0]            uimmd_ip;
  load_store_func_code    lsu_operator_ip;
  logic [1:0]             mem_addr_lo_ip;
  logic [31:0]            load_data_ip;
  logic                   load_data_valid_ip;
  logic                   regfile_we_op;
  logic [4:0]             regfile_waddr_op;
  logic [31:0]            regfile_wdata_op;
  logic                   fwd_valid_op;
  logic [4:0]             fwd_addr_op;
  logic [31:0]            fwd_data_op;
  logic                   stall_op;
  logic                   misalign_op;
  logic                   load_timeout_op;
  logic [31:0]            retired_count_op;

  wb_stage #(.LOAD_TIMEOUT(16), .RETIRE_W(32)) dut (
    .clock              (clock),
    .reset              (reset),
    .wb_valid_ip        (wb_valid_ip),
    .wb_mux_ip          (wb_mux_ip),
    .wb_alu_result_ip   (wb_alu_result_ip),
    .write_reg_addr_ip  (write_reg_addr_ip),
    .pc_addr_ip         (pc_addr_ip),
    .uimmd_ip           (uimmd_ip),
    .lsu_operator_ip    (lsu_operator_ip),
    .mem_addr_lo_ip     (mem_addr_lo_ip),
    .load_data_ip       (load_data_ip),
    .load_data_valid_ip (load_data_valid_ip),
    .regfile_we_op      (regfile_we_op),
    .regfile_waddr_op   (regfile_waddr_op),
    .regfile_wdata_op   (regfile_wdata_op),
    .fwd_valid_op       (fwd_valid_op),
    .fwd_addr_op        (fwd_addr_op),
    .fwd_data_op        (fwd_data_op),
    .stall_op           (stall_op),
    .misalign_op        (misalign_op),
    .load_timeout_op    (load_timeout_op),
    .retired_count_op   (retired_count_op)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic                   valid;
    write_back_mux_selector mux;
    logic [31:0]            alu;
    logic [4:0]             rd;
    logic [31:0]            pc;
    logic [31:0]            uimm;
    load_store_func_code    op;
    logic [1:0]             off;
    logic [31:0]            raw;
    logic                   ldv;
    logic                   exp_we;
    logic [4:0]             exp_waddr;
    logic [31:0]            exp_wdata;
    logic                   exp_mis;
    logic                   exp_retire;
  } vec_t;

  localparam logic [31:0] R = 32'h80FF7F01;

  vec_t vecs[20];
  int   n_pass  = 0;
  int   n_total = 0;
  logic [31:0] exp_count;
  logic        saw_we;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic idle_inputs();
    wb_valid_ip        = 1'b0;
    wb_mux_ip          = WB_ALU;
    wb_alu_result_ip   = 32'd0;
    write_reg_addr_ip  = 5'd0;
    pc_addr_ip         = 32'd0;
    uimmd_ip           = 32'd0;
    lsu_operator_ip    = LSU_NONE;
    mem_addr_lo_ip     = 2'b00;
    load_data_ip       = 32'd0;
    load_data_valid_ip = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    //            valid mux      alu          rd     pc            uimm          op        off    raw  ldv  we  waddr  wdata         mis  ret
    vecs[0]  = '{1'b1, WB_ALU,  32'h1234,    5'd5,  32'h0,        32'h0,        LSU_NONE, 2'd0, 32'h0, 1'b0, 1'b1, 5'd5,  32'h00001234, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, WB_LSU,  32'h0,       5'd8,  32'h0,        32'h0,        LSU_LB,   2'd3, R,     1'b1, 1'b1, 5'd8,  32'hFFFFFF80, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, WB_LSU,  32'h0,       5'd9,  32'h0,        32'h0,        LSU_LBU,  2'd2, R,     1'b1, 1'b1, 5'd9,  32'h000000FF, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, WB_LSU,  32'h0,       5'd10, 32'h0,        32'h0,        LSU_LHU,  2'd2, R,     1'b1, 1'b1, 5'd10, 32'h000080FF, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, WB_LSU,  32'h0,       5'd11, 32'h0,        32'h0,        LSU_LH,   2'd2, R,     1'b1, 1'b1, 5'd11, 32'hFFFF80FF, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, WB_LSU,  32'h0,       5'd12, 32'h0,        32'h0,        LSU_LB,   2'd1, R,     1'b1, 1'b1, 5'd12, 32'h0000007F, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, WB_LSU,  32'h0,       5'd13, 32'h0,        32'h0,        LSU_LB,   2'd0, R,     1'b1, 1'b1, 5'd13, 32'h00000001, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, WB_LSU,  32'h0,       5'd14, 32'h0,        32'h0,        LSU_LH,   2'd0, R,     1'b1, 1'b1, 5'd14, 32'h00007F01, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, WB_LSU,  32'h0,       5'd15, 32'h0,        32'h0,        LSU_LW,   2'd0, R,     1'b1, 1'b1, 5'd15, 32'h80FF7F01, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, WB_PC4,  32'h0,       5'd16, 32'hFFFFFFFC, 32'h0,        LSU_NONE, 2'd0, 32'h0, 1'b0, 1'b1, 5'd16, 32'h00000000, 1'b0, 1'b1};
    vecs[10] = '{1'b1, WB_PC4,  32'h0,       5'd17, 32'h00000100, 32'h0,        LSU_NONE, 2'd0, 32'h0, 1'b0, 1'b1, 5'd17, 32'h00000104, 1'b0, 1'b1};
    vecs[11] = '{1'b1, WB_UIMM, 32'h0,       5'd18, 32'h0,        32'hABCDE000, LSU_NONE, 2'd0, 32'h0, 1'b0, 1'b1, 5'd18, 32'hABCDE000, 1'b0, 1'b1};
    vecs[12] = '{1'b1, WB_ALU,  32'hDEAD,    5'd0,  32'h0,        32'h0,        LSU_NONE, 2'd0, 32'h0, 1'b0, 1'b0, 5'd18, 32'hABCDE000, 1'b0, 1'b1};
    vecs[13] = '{1'b0, WB_ALU,  32'h5,       5'd19, 32'h0,        32'h0,        LSU_NONE, 2'd0, 32'h0, 1'b0, 1'b0, 5'd18, 32'hABCDE000, 1'b0, 1'b0};
    vecs[14] = '{1'b1, WB_LSU,  32'h0,       5'd20, 32'h0,        32'h0,        LSU_LW,   2'd1, R,     1'b1, 1'b0, 5'd18, 32'hABCDE000, 1'b1, 1'b1};
    vecs[15] = '{1'b0, WB_ALU,  32'h0,       5'd0,  32'h0,        32'h0,        LSU_NONE, 2'd0, 32'h0, 1'b0, 1'b0, 5'd18, 32'hABCDE000, 1'b0, 1'b0};
    vecs[16] = '{1'b1, WB_LSU,  32'h0,       5'd21, 32'h0,        32'h0,        LSU_LHU,  2'd3, R,     1'b1, 1'b0, 5'd18, 32'hABCDE000, 1'b1, 1'b1};
    vecs[17] = '{1'b1, WB_LSU,  32'h0,       5'd22, 32'h0,        32'h0,        LSU_LH,   2'd1, R,     1'b1, 1'b0, 5'd18, 32'hABCDE000, 1'b1, 1'b1};
    vecs[18] = '{1'b1, WB_LSU,  32'h0,       5'd23, 32'h0,        32'h0,        LSU_LBU,  2'd3, R,     1'b1, 1'b1, 5'd23, 32'h00000080, 1'b0, 1'b1};
    vecs[19] = '{1'b1, WB_ALU,  32'h55,      5'd24, 32'h0,        32'h0,        LSU_LW,   2'd1, R,     1'b1, 1'b1, 5'd24, 32'h00000055, 1'b0, 1'b1};

    idle_inputs();
    reset = 1'b0;
    #12;
    check("reset_we",     {31'd0, regfile_we_op},    32'd0);
    check("reset_waddr",  {27'd0, regfile_waddr_op}, 32'd0);
    check("reset_wdata",  regfile_wdata_op,          32'd0);
    check("reset_stall",  {31'd0, stall_op},         32'd0);
    check("reset_tmo",    {31'd0, load_timeout_op},  32'd0);
    check("reset_count",  retired_count_op,          32'd0);
    reset = 1'b1;
    @(negedge clock);
    exp_count = 32'd0;

    for (int i = 0; i < 20; i++) begin
      wb_valid_ip        = vecs[i].valid;
      wb_mux_ip          = vecs[i].mux;
      wb_alu_result_ip   = vecs[i].alu;
      write_reg_addr_ip  = vecs[i].rd;
      pc_addr_ip         = vecs[i].pc;
      uimmd_ip           = vecs[i].uimm;
      lsu_operator_ip    = vecs[i].op;
      mem_addr_lo_ip     = vecs[i].off;
      load_data_ip       = vecs[i].raw;
      load_data_valid_ip = vecs[i].ldv;
      tick();
      if (vecs[i].exp_retire) exp_count = exp_count + 32'd1;
      $display("vec %0d: we=%0d waddr=%0d wdata=0x%08h mis=%0d count=%0d",
               i, regfile_we_op, regfile_waddr_op, regfile_wdata_op, misalign_op, retired_count_op);
      check($sformatf("v%0d_we", i),    {31'd0, regfile_we_op},    {31'd0, vecs[i].exp_we});
      check($sformatf("v%0d_waddr", i), {27'd0, regfile_waddr_op}, {27'd0, vecs[i].exp_waddr});
      check($sformatf("v%0d_wdata", i), regfile_wdata_op,          vecs[i].exp_wdata);
      check($sformatf("v%0d_mis", i),   {31'd0, misalign_op},      {31'd0, vecs[i].exp_mis});
      check($sformatf("v%0d_count", i), retired_count_op,          exp_count);
      check($sformatf("v%0d_fwdv", i),  {31'd0, fwd_valid_op},     {31'd0, vecs[i].exp_we});
      check($sformatf("v%0d_fwdd", i),  fwd_data_op,               vecs[i].exp_wdata);
      check($sformatf("v%0d_fwda", i),  {27'd0, fwd_addr_op},      {27'd0, vecs[i].exp_waddr});
    end
    idle_inputs();
    tick();

    // Delayed load: LH at offset 2 into x7, data three cycles later.
    wb_valid_ip       = 1'b1;
    wb_mux_ip         = WB_LSU;
    write_reg_addr_ip = 5'd7;
    lsu_operator_ip   = LSU_LH;
    mem_addr_lo_ip    = 2'd2;
    tick();
    // Upstream fields change while waiting; the captured ones must be used.
    wb_mux_ip         = WB_ALU;
    wb_alu_result_ip  = 32'h11111111;
    write_reg_addr_ip = 5'd3;
    lsu_operator_ip   = LSU_LW;
    mem_addr_lo_ip    = 2'd0;
    saw_we = 1'b0;
    for (int c = 0; c < 2; c++) begin
      check($sformatf("dly_stall%0d", c), {31'd0, stall_op}, 32'd1);
      saw_we = saw_we | regfile_we_op;
      tick();
    end
    check("dly_stall2", {31'd0, stall_op}, 32'd1);
    saw_we = saw_we | regfile_we_op;
    check("dly_no_write", {31'd0, saw_we}, 32'd0);
    wb_valid_ip        = 1'b0;
    load_data_ip       = 32'h80010000;
    load_data_valid_ip = 1'b1;
    tick();
    exp_count = exp_count + 32'd1;
    $display("delayed load: we=%0d waddr=%0d wdata=0x%08h stall=%0d", regfile_we_op, regfile_waddr_op, regfile_wdata_op, stall_op);
    check("dly_we",    {31'd0, regfile_we_op},    32'd1);
    check("dly_waddr", {27'd0, regfile_waddr_op}, 32'd7);
    check("dly_wdata", regfile_wdata_op,          32'hFFFF8001);
    check("dly_stall_rel", {31'd0, stall_op},     32'd0);
    check("dly_count", retired_count_op,          exp_count);
    idle_inputs();
    tick();
    check("dly_we_pulse", {31'd0, regfile_we_op}, 32'd0);

    // Timeout: 16 cycles in WAIT_LOAD, then abandon.
    wb_valid_ip       = 1'b1;
    wb_mux_ip         = WB_LSU;
    write_reg_addr_ip = 5'd9;
    lsu_operator_ip   = LSU_LW;
    tick();
    wb_valid_ip = 1'b0;
    saw_we = 1'b0;
    for (int c = 0; c < 15; c++) begin
      tick();
      saw_we = saw_we | regfile_we_op;
    end
    check("tmo_stall15", {31'd0, stall_op},        32'd1);
    check("tmo_early",   {31'd0, load_timeout_op}, 32'd0);
    tick();
    saw_we = saw_we | regfile_we_op;
    $display("timeout: tmo=%0d stall=%0d count=%0d", load_timeout_op, stall_op, retired_count_op);
    check("tmo_set",      {31'd0, load_timeout_op}, 32'd1);
    check("tmo_stall",    {31'd0, stall_op},        32'd0);
    check("tmo_no_write", {31'd0, saw_we},          32'd0);
    check("tmo_count",    retired_count_op,         exp_count);
    tick();
    check("tmo_sticky",   {31'd0, load_timeout_op}, 32'd1);
    wb_valid_ip       = 1'b1;
    wb_mux_ip         = WB_ALU;
    wb_alu_result_ip  = 32'h0000BEEF;
    write_reg_addr_ip = 5'd4;
    tick();
    exp_count = exp_count + 32'd1;
    check("post_tmo_we",    {31'd0, regfile_we_op}, 32'd1);
    check("post_tmo_wdata", regfile_wdata_op,       32'h0000BEEF);
    check("post_tmo_count", retired_count_op,       exp_count);

    // Async reset in the middle of WAIT_LOAD.
    wb_mux_ip         = WB_LSU;
    write_reg_addr_ip = 5'd6;
    lsu_operator_ip   = LSU_LW;
    tick();
    wb_valid_ip = 1'b0;
    tick();
    check("rst_pre_stall", {31'd0, stall_op}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    $display("async reset: stall=%0d waddr=%0d wdata=0x%08h tmo=%0d count=%0d", stall_op, regfile_waddr_op, regfile_wdata_op, load_timeout_op, retired_count_op);
    check("rst_stall", {31'd0, stall_op},         32'd0);
    check("rst_waddr", {27'd0, regfile_waddr_op}, 32'd0);
    check("rst_wdata", regfile_wdata_op,          32'd0);
    check("rst_fwdd",  fwd_data_op,               32'd0);
    check("rst_tmo",   {31'd0, load_timeout_op},  32'd0);
    check("rst_count", retired_count_op,          32'd0);
    @(negedge clock);
    reset = 1'b1;
    load_data_ip       = 32'h12345678;
    load_data_valid_ip = 1'b1;
    tick();
    check("rst_late_we",    {31'd0, regfile_we_op}, 32'd0);
    check("rst_late_count", retired_count_op,       32'd0);
    idle_inputs();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
